riscv_divider: RTL and testbench
================================

# riscv_divider

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the EX stage beside the single-cycle multiplier. It consumes the same ID-stage operand registers and signedness flags. It holds the pipeline through `ex_stall_div_w` while it iterates, then presents a registered 32-bit quotient or remainder for exactly one cycle. Divide-by-zero and signed overflow complete on a fast path with RISC-V-mandated results.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk_i` input 1: clock, rising edge.
- `reset_i` input 1: asynchronous, active-high reset.
- `id_div_valid_r` input 1: a divide-class instruction occupies EX. Held high while stalled.
- `id_div_signed_r` input 1: 1 for DIV/REM, 0 for DIVU/REMU.
- `id_div_rem_r` input 1: 1 returns the remainder, 0 returns the quotient.
- `id_ra_value_r` input 32: dividend.
- `id_rb_value_r` input 32: divisor.
- `ex_flush_i` input 1: kill the in-flight operation. Takes priority over everything except reset.
- `div_res_w` output 32: result register.
- `div_valid_w` output 1: result valid, one-cycle pulse.
- `ex_stall_div_w` output 1: pipeline hold request.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE, `id_div_valid_r`=1, `ex_flush_i`=0:**
  - Latch the op flags.
  - Latch |a| and |b|. Absolute value is taken only when `id_div_signed_r`=1 and bit 31 is set.
  - Latch neg_q = sa^sb and neg_r = sa, where sa and sb are the effective sign bits.
  - Clear the partial remainder and load count=31.
- **Special case, b==0:**
  - Next state DONE.
  - Quotient = 0xFFFFFFFF.
  - Remainder = a, raw and un-negated.
- **Special case, signed a==0x80000000 and b==0xFFFFFFFF:**
  - Next state DONE.
  - Quotient = 0x80000000.
  - Remainder = 0.
- **Otherwise:** next state BUSY.
- **BUSY, one restoring step per cycle (33-bit subtract):**
  - Shift {rem,quo} left by 1.
  - trial = rem − |b|.
  - If trial ≥ 0, rem = trial and the quotient LSB = 1.
  - count decrements. When count==0, next state DONE.
- **DONE entry, magnitude result:**
  - Result = neg_q ? −quo : quo when `id_div_rem_r`=0.
  - Result = neg_r ? −rem : rem when `id_div_rem_r`=1.
  - This value is registered into `div_res_w`.
  - `div_valid_w`=1.
- **DONE exit:** always returns to IDLE. The still-asserted `id_div_valid_r` from the same instruction is ignored in DONE.
- **`ex_flush_i`=1 in any state:**
  - Next state IDLE.
  - No `div_valid_w` pulse.
  - `div_res_w` is unchanged.
- `ex_stall_div_w` = ~reset_i & ~ex_flush_i & ((IDLE & `id_div_valid_r`) | BUSY). It is combinational and low in DONE.
- Operands are sampled only in IDLE. Changes on `id_ra_value_r`/`id_rb_value_r` during BUSY have no effect.

## Timing
- **Reset (async):**
  - State = IDLE, count = 0.
  - `div_res_w` = 0, `div_valid_w` = 0.
  - `ex_stall_div_w` = 0 while `reset_i` is high.
- **Normal operation:**
  - Start edge is cycle 0 (IDLE, valid).
  - BUSY occupies cycles 1–32.
  - DONE is cycle 33, with `div_valid_w`=1 and the result on `div_res_w`.
  - Stall is high for cycles 0–32 (33 cycles) and low in cycle 33, so the pipeline advances.
- **Fast path:**
  - Stall is high in cycle 0 only.
  - DONE is cycle 1.
- **Back-to-back:** a new divide may be presented in the cycle after DONE and starts from IDLE with no bubble.
- `div_res_w` holds its last value until the next DONE.
- `div_valid_w` is a registered single-cycle pulse.
- **Reset asserted mid-BUSY:** outputs go to reset values immediately. No partial result is ever flagged valid.

## Test plan
- DIVU 100/7 → `div_valid_w` at cycle 33, `div_res_w`=14. Repeat with REMU → 2. Check stall is high for exactly 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- Divide by zero:
  - DIV 1234/0 → 0xFFFFFFFF at cycle 1.
  - REM −5/0 → 0xFFFFFFFB at cycle 1.
  - Stall is high for one cycle only.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM → 0. Both arrive at cycle 1.
- Assert `ex_flush_i` at cycle 10 of a divide:
  - Stall drops in the same cycle.
  - No `div_valid_w` pulse.
  - `div_res_w` is unchanged.
  - A following DIVU 9/3 → 3 with normal latency.
- Back-to-back DIVU 50/5 then REMU 50/8 → valid pulses at cycles 33 and 67, results 10 then 2.
- Separately, assert `reset_i` mid-BUSY → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/riscv_divider.sv
// riscv_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Works on operand magnitudes for 32 cycles, then applies the result sign.
// Divide-by-zero and signed overflow finish in one cycle with the RISC-V results.
module riscv_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            id_div_valid_r,
    input  logic            id_div_signed_r,
    input  logic            id_div_rem_r,
    input  logic [XLEN-1:0] id_ra_value_r,
    input  logic [XLEN-1:0] id_rb_value_r,
    input  logic            ex_flush_i,
    output logic [XLEN-1:0] div_res_w,
    output logic            div_valid_w,
    output logic            ex_stall_div_w
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Two's-complement negate when requested.
    function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] x, input logic neg);
        logic [XLEN-1:0] one;
        one = {{(XLEN-1){1'b0}}, 1'b1};
        return neg ? (~x + one) : x;
    endfunction

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              valid_q, valid_d;

    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              rem_op_q, rem_op_d;

    // Operand decode for the start cycle.
    logic              sa, sb;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              b_zero, ovf;

    // One restoring step on the current partial remainder/quotient.
    logic [XLEN:0]     rem_sh, trial;
    logic              trial_ok;
    logic [XLEN-1:0]   rem_step, quo_step;

    assign sa     = id_div_signed_r & id_ra_value_r[XLEN-1];
    assign sb     = id_div_signed_r & id_rb_value_r[XLEN-1];
    assign abs_a  = negate_if(id_ra_value_r, sa);
    assign abs_b  = negate_if(id_rb_value_r, sb);
    assign b_zero = (id_rb_value_r == '0);
    assign ovf    = id_div_signed_r
                  & (id_ra_value_r == {1'b1, {(XLEN-1){1'b0}}})
                  & (id_rb_value_r == '1);

    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign trial_ok = ~trial[XLEN];
    assign rem_step = trial_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_step = {quo_q[XLEN-2:0], trial_ok};

    // Next-state, datapath update and result capture.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        res_d    = res_q;
        valid_d  = 1'b0;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        rem_op_d = rem_op_q;

        if (ex_flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (id_div_valid_r) begin
                        rem_op_d = id_div_rem_r;
                        negq_d   = sa ^ sb;
                        negr_d   = sa;
                        dvs_d    = abs_b;
                        quo_d    = abs_a;
                        rem_d    = '0;
                        count_d  = CNT_W'(XLEN - 1);
                        if (b_zero) begin
                            // Remainder is the raw dividend, quotient all ones.
                            state_d = ST_DONE;
                            valid_d = 1'b1;
                            res_d   = id_div_rem_r ? id_ra_value_r : '1;
                        end else if (ovf) begin
                            state_d = ST_DONE;
                            valid_d = 1'b1;
                            res_d   = id_div_rem_r ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    if (count_q == '0) begin
                        state_d = ST_DONE;
                        valid_d = 1'b1;
                        res_d   = rem_op_q ? negate_if(rem_step, negr_q)
                                           : negate_if(quo_step, negq_q);
                    end else begin
                        count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    // The instruction that just completed is still on the inputs; ignore it.
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state, counter and result registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    // Iteration datapath; only meaningful between start and DONE, so no reset.
    always_ff @(posedge clk_i) begin
        rem_q    <= rem_d;
        quo_q    <= quo_d;
        dvs_q    <= dvs_d;
        negq_q   <= negq_d;
        negr_q   <= negr_d;
        rem_op_q <= rem_op_d;
    end

    assign div_res_w      = res_q;
    assign div_valid_w    = valid_q;
    assign ex_stall_div_w = ~reset_i & ~ex_flush_i
                          & (((state_q == ST_IDLE) & id_div_valid_r) | (state_q == ST_BUSY));

endmodule

// File: tb/tb_riscv_divider.sv
// Scoreboard bench for riscv_divider: stimulus pushes expected result and
// completion cycle; a monitor pops and compares on every div_valid_w pulse.
module tb_riscv_divider;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        id_div_valid_r;
    logic        id_div_signed_r;
    logic        id_div_rem_r;
    logic [31:0] id_ra_value_r;
    logic [31:0] id_rb_value_r;
    logic        ex_flush_i;
    logic [31:0] div_res_w;
    logic        div_valid_w;
    logic        ex_stall_div_w;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    riscv_divider #(.XLEN(32)) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .id_div_valid_r (id_div_valid_r),
        .id_div_signed_r(id_div_signed_r),
        .id_div_rem_r   (id_div_rem_r),
        .id_ra_value_r  (id_ra_value_r),
        .id_rb_value_r  (id_rb_value_r),
        .ex_flush_i     (ex_flush_i),
        .div_res_w      (div_res_w),
        .div_valid_w    (div_valid_w),
        .ex_stall_div_w (ex_stall_div_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (div_valid_w === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_valid: got res %h with no operation outstanding", div_res_w);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check32("result", div_res_w, e.val);
                check_int("valid_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one divide, hold valid while stalled, and check the stall length.
    task automatic run_op(input logic sg, input logic rm, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int n;
        int c0;
        @(negedge clk);
        id_div_signed_r = sg;
        id_div_rem_r    = rm;
        id_ra_value_r   = a;
        id_rb_value_r   = b;
        id_div_valid_r  = 1'b1;
        c0 = cyc;
        sb_q.push_back('{val: exp, cyc: c0 + lat});
        #1;
        n = 0;
        while (ex_stall_div_w === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_int("stall_len", n, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_i         = 1'b1;
        id_div_valid_r  = 1'b1;
        id_div_signed_r = 1'b0;
        id_div_rem_r    = 1'b0;
        id_ra_value_r   = 32'd100;
        id_rb_value_r   = 32'd7;
        ex_flush_i      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check32("reset_res", div_res_w, 32'h0);
        check32("reset_valid", {31'b0, div_valid_w}, 32'h0);
        check32("reset_stall", {31'b0, ex_stall_div_w}, 32'h0);
        @(negedge clk);
        reset_i        = 1'b0;
        id_div_valid_r = 1'b0;

        run_op(1'b0, 1'b0, 32'd100,       32'd7,       32'd14,        33);
        run_op(1'b0, 1'b1, 32'd100,       32'd7,       32'd2,         33);
        run_op(1'b1, 1'b0, 32'hFFFFFFF9,  32'd2,       32'hFFFFFFFD,  33);
        run_op(1'b1, 1'b1, 32'hFFFFFFF9,  32'd2,       32'hFFFFFFFF,  33);
        run_op(1'b1, 1'b1, 32'd7,         32'hFFFFFFFE, 32'd1,        33);
        run_op(1'b0, 1'b0, 32'hFFFFFFFF,  32'd1,       32'hFFFFFFFF,  33);

        // Flush at cycle 10 of DIVU 1000/3: no pulse, result register untouched.
        begin
            @(negedge clk);
            id_div_signed_r = 1'b0;
            id_div_rem_r    = 1'b0;
            id_ra_value_r   = 32'd1000;
            id_rb_value_r   = 32'd3;
            id_div_valid_r  = 1'b1;
            repeat (10) @(negedge clk);
            ex_flush_i = 1'b1;
            #1;
            check32("flush_stall", {31'b0, ex_stall_div_w}, 32'h0);
            @(negedge clk);
            ex_flush_i     = 1'b0;
            id_div_valid_r = 1'b0;
            repeat (40) @(negedge clk);
            #1;
            check32("flush_res_held", div_res_w, 32'hFFFFFFFF);
        end
        run_op(1'b0, 1'b0, 32'd9,         32'd3,       32'd3,         33);

        run_op(1'b1, 1'b0, 32'd1234,      32'd0,       32'hFFFFFFFF,  1);
        run_op(1'b1, 1'b1, 32'hFFFFFFFB,  32'd0,       32'hFFFFFFFB,  1);
        run_op(1'b1, 1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1);
        run_op(1'b1, 1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h0,        1);
        run_op(1'b0, 1'b0, 32'h80000000,  32'hFFFFFFFF, 32'h0,        33);

        run_op(1'b0, 1'b0, 32'd50,        32'd5,       32'd10,        33);
        run_op(1'b0, 1'b1, 32'd50,        32'd8,       32'd2,         33);

        // Reset mid-BUSY: outputs clear immediately, no pulse afterwards.
        begin
            @(negedge clk);
            id_div_signed_r = 1'b0;
            id_div_rem_r    = 1'b0;
            id_ra_value_r   = 32'd1000;
            id_rb_value_r   = 32'd3;
            id_div_valid_r  = 1'b1;
            repeat (10) @(negedge clk);
            #1;
            check32("pre_reset_res", div_res_w, 32'd2);
            reset_i = 1'b1;
            #1;
            check32("midreset_res", div_res_w, 32'h0);
            check32("midreset_valid", {31'b0, div_valid_w}, 32'h0);
            check32("midreset_stall", {31'b0, ex_stall_div_w}, 32'h0);
            @(negedge clk);
            id_div_valid_r = 1'b0;
            reset_i        = 1'b0;
            repeat (40) @(negedge clk);
        end
        run_op(1'b0, 1'b0, 32'd7,         32'd7,       32'd1,         33);

        @(negedge clk);
        id_div_valid_r = 1'b0;
        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
